pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard/forwarding controller for the pipelined RV32 core.
- Replaces the fixed load-use detector and the fixed two-source forwarding unit.
- Keeps a shift scoreboard of in-flight destination registers for DEPTH post-ID stages and issues registered forward selects aligned to EX.
- Generates combinational PC-stall / IF-ID hold / IF-ID flush / ID-EX bubble controls, supports external freeze and a load-latency parameter, and counts load-use stall cycles.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/hazard_src_match.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   sb_entry_t    : one scoreboard slot {valid, destination register, is-load}
//   ctrl_mode_t   : resolved pipeline-control priority for the current cycle
//   FWD_*         : operand-source encodings for the EX-stage forward muxes
//   hazard_params_ok : elaboration-time legality check of the top parameters
package pipe_pkg;

  // Wide enough for any register file up to 256 entries. Narrower
  // addresses are zero-extended, so the unused upper bits stay constant.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               v;
    logic [SB_RD_W-1:0] rd;
    logic               load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: '0, load: 1'b0};

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_FREEZE   = 2'd1,
    MODE_REDIRECT = 2'd2,
    MODE_LOAD_USE = 2'd3
  } ctrl_mode_t;

  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // LOAD_LAT >= 1 and LOAD_LAT <= DEPTH-2 together force DEPTH >= 3.
  function automatic bit hazard_params_ok(input int reg_aw, input int depth,
                                          input int load_lat);
    return (reg_aw >= 1) && (reg_aw <= SB_RD_W) && (depth >= 2) &&
           (load_lat >= 1) && (load_lat <= depth - 2);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one source register against the forwardable part of the
// scoreboard (entries 0..DEPTH-2). The youngest producer (lowest index) wins.
// Ports:
//   sb_i       : scoreboard entries, index 0 = instruction currently in EX
//   rs_i       : source register of the instruction in ID
//   rs_used_i  : the instruction actually reads rs_i
//   hit_o      : a valid in-flight producer writes rs_i
//   idx_o      : scoreboard index of that producer
//   is_load_o  : that producer is a load
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  sb_entry_t [DEPTH-2:0]        sb_i,
  input  logic [REG_AW-1:0]            rs_i,
  input  logic                         rs_used_i,
  output logic                         hit_o,
  output logic [$clog2(DEPTH)-1:0]     idx_o,
  output logic                         is_load_o
);

  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    // x0 is hard-wired to zero and never has a producer worth forwarding.
    if (rs_used_i && (rs_i != '0)) begin
      // Walk oldest to youngest so the youngest match overwrites the rest.
      for (int i = DEPTH - 2; i >= 0; i--) begin
        if (sb_i[i].v && (sb_i[i].rd == SB_RD_W'(rs_i))) begin
          hit_o     = 1'b1;
          idx_o     = IDX_W'(i);
          is_load_o = sb_i[i].load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and operand-forwarding controller for the pipelined RV32
// core. Tracks in-flight destination registers in a shift scoreboard, issues
// EX-aligned registered forward selects, and drives the front-end stall,
// flush and bubble controls combinationally from the ID-stage instruction.
// Ports:
//   clk, rst                : pipeline clock, asynchronous active-low reset
//   id_*                    : decoded fields of the instruction in ID
//   ex_redirect             : taken branch/jump resolved in EX this cycle
//   ext_stall               : freeze the whole pipeline
//   pc_stall, ifid_hold     : hold PC / IF-ID register
//   ifid_flush, idex_bubble : squash IF-ID / inject NOP into ID-EX
//   fwd_a, fwd_b            : EX operand source, 0 = regfile, k = k stages ahead
//   stall_cycles            : saturating count of load-use stall cycles
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     ex_redirect,
  input  logic                     ext_stall,
  output logic                     pc_stall,
  output logic                     ifid_hold,
  output logic                     ifid_flush,
  output logic                     idex_bubble,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int FW = $clog2(DEPTH);
  // The WB slot (entry DEPTH-1) is never forwarded from because the regfile
  // writes before it reads, so only entries 0..DEPTH-2 are stored.
  localparam int SB_N = DEPTH - 1;

  if (!hazard_params_ok(REG_AW, DEPTH, LOAD_LAT)) begin : g_param_check
    $error("pipe_hazard_ctrl: illegal REG_AW/DEPTH/LOAD_LAT combination");
  end

  sb_entry_t [SB_N-1:0] sb_q, sb_d;
  logic [FW-1:0]        fwd_a_q, fwd_a_d;
  logic [FW-1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic          hit_a, hit_b;
  logic [FW-1:0] idx_a, idx_b;
  logic          ld_a, ld_b;
  logic          haz_a, haz_b;
  logic          load_use;
  ctrl_mode_t    mode;

  hazard_src_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match_rs1 (
    .sb_i      (sb_q),
    .rs_i      (id_rs1),
    .rs_used_i (id_rs1_used),
    .hit_o     (hit_a),
    .idx_o     (idx_a),
    .is_load_o (ld_a)
  );

  hazard_src_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match_rs2 (
    .sb_i      (sb_q),
    .rs_i      (id_rs2),
    .rs_used_i (id_rs2_used),
    .hit_o     (hit_b),
    .idx_o     (idx_b),
    .is_load_o (ld_b)
  );

  // Only the youngest producer matters: an older load shadowed by a younger
  // ALU write of the same register is not a hazard.
  assign haz_a    = hit_a && ld_a && (int'(idx_a) < LOAD_LAT);
  assign haz_b    = hit_b && ld_b && (int'(idx_b) < LOAD_LAT);
  assign load_use = id_valid && (haz_a || haz_b);

  always_comb begin
    if (ext_stall) begin
      mode = MODE_FREEZE;
    end else if (ex_redirect) begin
      mode = MODE_REDIRECT;
    end else if (load_use) begin
      mode = MODE_LOAD_USE;
    end else begin
      mode = MODE_RUN;
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (mode)
      MODE_FREEZE: begin
        pc_stall  = 1'b1;
        ifid_hold = 1'b1;
      end
      MODE_REDIRECT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      MODE_LOAD_USE: begin
        pc_stall    = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sb_d    = sb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (mode != MODE_FREEZE) begin
      for (int i = SB_N - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0] = SB_EMPTY;
      fwd_a_d = '0;
      fwd_b_d = '0;
      if ((mode == MODE_RUN) && id_valid) begin
        if (id_regwrite && (id_rd != '0)) begin
          sb_d[0] = '{v: 1'b1, rd: SB_RD_W'(id_rd), load: id_is_load};
        end
        // Producer at entry i sits i+1 stages ahead of the consumer once
        // the consumer reaches EX next cycle.
        if (hit_a) fwd_a_d = FW'(FWD_MEM) + idx_a;
        if (hit_b) fwd_b_d = FW'(FWD_MEM) + idx_b;
      end
      if ((mode == MODE_LOAD_USE) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      sb_q    <= sb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pipeline scenarios
// followed by randomized traffic, all compared against a queue-based model
// of the in-flight producers.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int FW       = $clog2(DEPTH);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_redirect, ext_stall;
  logic              pc_stall, ifid_hold, ifid_flush, idex_bubble;
  logic [FW-1:0]     fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW   (REG_AW),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .ext_stall    (ext_stall),
    .pc_stall     (pc_stall),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: list of instructions that have left ID, youngest first.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } prod_t;

  prod_t inflight[$];
  int    m_fwd_a, m_fwd_b, m_cnt;

  function automatic int youngest(input int rs, input bit used);
    if (!used || rs == 0) return -1;
    for (int i = 0; i < DEPTH - 1; i++)
      if (inflight[i].v && inflight[i].rd == rs) return i;
    return -1;
  endfunction

  task automatic model_reset();
    inflight.delete();
    for (int i = 0; i < DEPTH; i++) inflight.push_back(prod_t'{0, 0, 0});
    m_fwd_a = 0;
    m_fwd_b = 0;
    m_cnt   = 0;
  endtask

  task automatic cyc(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit rw, input bit ld, input bit redir, input bit frz,
                     output bit issued, output bit stalled);
    int       h1, h2;
    bit       lu;
    logic [3:0] exp_ctl;
    prod_t    ins;
    id_valid    = v;
    id_rs1      = REG_AW'(rs1);
    id_rs2      = REG_AW'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = REG_AW'(rd);
    id_regwrite = rw;
    id_is_load  = ld;
    ex_redirect = redir;
    ext_stall   = frz;
    h1 = youngest(rs1, u1);
    h2 = youngest(rs2, u2);
    lu = v && ((h1 >= 0 && inflight[h1].ld && h1 < LOAD_LAT) ||
               (h2 >= 0 && inflight[h2].ld && h2 < LOAD_LAT));
    if (frz)        exp_ctl = 4'b1100;
    else if (redir) exp_ctl = 4'b0011;
    else if (lu)    exp_ctl = 4'b1101;
    else            exp_ctl = 4'b0000;
    @(negedge clk);
    chk("ctl{pc,hold,flush,bubble}", {28'd0, pc_stall, ifid_hold, ifid_flush, idex_bubble}, {28'd0, exp_ctl});
    chk("fwd_a", 32'(fwd_a), m_fwd_a);
    chk("fwd_b", 32'(fwd_b), m_fwd_b);
    chk("stall_cycles", 32'(stall_cycles), m_cnt);
    issued  = !frz && !redir && !lu;
    stalled = !frz && !redir && lu;
    if (!frz) begin
      if (issued && v && rw && rd != 0) ins = prod_t'{1, rd, ld};
      else                              ins = prod_t'{0, 0, 0};
      inflight.push_front(ins);
      void'(inflight.pop_back());
      m_fwd_a = (issued && v && h1 >= 0) ? h1 + 1 : 0;
      m_fwd_b = (issued && v && h2 >= 0) ? h2 + 1 : 0;
      if (stalled && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit iss, st;
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iss, st);
  endtask

  // Present one instruction in ID until it issues; returns stall cycles seen.
  task automatic run_ins(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, output int n_stall);
    bit iss, st;
    int tries;
    tries   = 0;
    n_stall = 0;
    do begin
      cyc(1, rs1, u1, rs2, u2, rd, rw, ld, 0, 0, iss, st);
      if (st) n_stall++;
      tries++;
    end while (!iss && tries < 8);
    if (!iss) chk("issue_bound", 0, 1);
  endtask

  initial begin
    int ns;
    bit iss, st;
    bit rv, ru1, ru2, rrw, rld, rredir, rfrz;
    int rrs1, rrs2, rrd;

    rst = 1'b0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_regwrite = 0; id_is_load = 0; ex_redirect = 0; ext_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", 32'(fwd_a), FWD_RF);
    chk("rst_fwd_b", 32'(fwd_b), FWD_RF);
    chk("rst_cnt", 32'(stall_cycles), 0);
    chk("rst_ctl", {28'd0, pc_stall, ifid_hold, ifid_flush, idex_bubble}, 0);
    #1 rst = 1'b1;

    // ALU to ALU: add x5,x1,x2 ; add x6,x5,x1
    run_ins(1, 1, 2, 1, 5, 1, 0, ns);
    run_ins(5, 1, 1, 1, 6, 1, 0, ns);
    chk("alu_nostall", ns, 0);
    chk("alu_fwd_a", 32'(fwd_a), FWD_MEM);
    chk("alu_fwd_b", 32'(fwd_b), FWD_RF);

    // Load-use: lw x5,0(x1) ; add x7,x5,x5
    idle(3);
    run_ins(1, 1, 0, 0, 5, 1, 1, ns);
    run_ins(5, 1, 5, 1, 7, 1, 0, ns);
    chk("lu_stalls", ns, 1);
    chk("lu_fwd_a", 32'(fwd_a), FWD_WB);
    chk("lu_fwd_b", 32'(fwd_b), FWD_WB);
    chk("lu_cnt", 32'(stall_cycles), 1);

    // x0 destination: addi x0,x1 ; add x1,x0,x0
    idle(3);
    run_ins(1, 1, 0, 0, 0, 1, 0, ns);
    run_ins(0, 1, 0, 1, 1, 1, 0, ns);
    chk("x0_nostall", ns, 0);
    chk("x0_fwd_a", 32'(fwd_a), FWD_RF);
    chk("x0_fwd_b", 32'(fwd_b), FWD_RF);

    // Double producer: add x5 ; sub x5 ; or x8,x5,x9
    idle(3);
    run_ins(1, 1, 2, 1, 5, 1, 0, ns);
    run_ins(3, 1, 4, 1, 5, 1, 0, ns);
    run_ins(5, 1, 9, 1, 8, 1, 0, ns);
    chk("dbl_fwd_a", 32'(fwd_a), FWD_MEM);
    chk("dbl_fwd_b", 32'(fwd_b), FWD_RF);

    // Redirect coinciding with a load-use hazard
    idle(3);
    run_ins(1, 1, 0, 0, 5, 1, 1, ns);
    cyc(1, 5, 1, 5, 1, 7, 1, 0, 1, 0, iss, st);
    chk("redir_not_stalled", st, 0);
    chk("redir_cnt", 32'(stall_cycles), 1);
    chk("redir_fwd_a", 32'(fwd_a), FWD_RF);

    // Freeze during a pending load-use, then reset mid-stall
    idle(3);
    run_ins(1, 1, 2, 1, 5, 1, 0, ns);
    run_ins(5, 1, 0, 0, 6, 1, 1, ns);
    for (int k = 0; k < 3; k++) cyc(1, 6, 1, 6, 1, 7, 1, 0, 0, 1, iss, st);
    chk("frz_fwd_a", 32'(fwd_a), FWD_MEM);
    chk("frz_cnt", 32'(stall_cycles), 1);
    ext_stall = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_fwd_a", 32'(fwd_a), FWD_RF);
    chk("midrst_fwd_b", 32'(fwd_b), FWD_RF);
    chk("midrst_cnt", 32'(stall_cycles), 0);
    chk("midrst_ctl", {28'd0, pc_stall, ifid_hold, ifid_flush, idex_bubble}, 0);
    #1 rst = 1'b1;
    run_ins(6, 1, 6, 1, 7, 1, 0, ns);
    chk("postrst_nostall", ns, 0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rv     = ($urandom_range(0, 99) < 85);
      rrs1   = $urandom_range(0, 7);
      rrs2   = $urandom_range(0, 7);
      ru1    = ($urandom_range(0, 99) < 80);
      ru2    = ($urandom_range(0, 99) < 60);
      rrd    = $urandom_range(0, 7);
      rrw    = ($urandom_range(0, 99) < 75);
      rld    = ($urandom_range(0, 99) < 35);
      rredir = ($urandom_range(0, 99) < 8);
      rfrz   = ($urandom_range(0, 99) < 10);
      cyc(rv, rrs1, ru1, rrs2, ru2, rrd, rrw, rld, rredir, rfrz, iss, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
